disp_ctrl: RTL and testbench
============================

Name: disp_ctrl

Overview:
Display controller that sits between the stopwatch counters and the 4-digit 7-segment multiplexer. It sequentially converts the binary minute and second values to BCD, then drives the four digit codes consumed by the mux. It also sequences lap-freeze and the adjust-mode blink of the selected digit pair.

Parameters:
BLINK_DIV, 25000000, CLK cycles per blink half-period; must be at least 2.
MAX_VAL, 59, largest value shown for a pair; larger values show dash codes.
BLANK_CODE, 4'hF, digit code sent during the blink-off phase.
DASH_CODE, 4'hA, digit code sent for out-of-range values.

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
min_bin  in  6  binary minutes, 0..63
sec_bin  in  6  binary seconds, 0..63
adj_en  in  1  adjust mode is active
adj_sel  in  1  pair under adjustment: 0 = seconds (d1,d0), 1 = minutes (d3,d2)
lap_pulse  in  1  one-cycle lap button strobe
d0  out  4  seconds ones
d1  out  4  seconds tens
d2  out  4  minutes ones
d3  out  4  minutes tens
busy  out  1  high while a conversion is in flight
lap_active  out  1  high while the display is frozen

Behaviour:
- Reset: CLK, RESET synchronous, active-high. On reset:
  - d0..d3=0, busy=0, lap_active=0.
  - Snapshot registers=0, committed BCD=0.
  - Blink counter=0, blink phase=0 (visible), FSM=IDLE.
- FSM states: IDLE, CONV, COMMIT.
  - IDLE: if {min_bin,sec_bin} differs from the snapshot, or a reconvert flag is set, then:
    - capture both inputs into the snapshot and the shift registers;
    - clear the reconvert flag;
    - set busy=1 and go to CONV.
  - CONV: exactly 6 cycles of double-dabble. Add 3 to any BCD nibble >=5, then shift left one bit. Both pairs are converted in parallel.
  - COMMIT: one cycle.
    - If lap_active=0, write the BCD results to the committed registers. A pair whose snapshot value > MAX_VAL commits DASH_CODE in both of its digits.
    - busy=0, return to IDLE.
- Input changes during CONV/COMMIT are ignored. They are re-detected in IDLE against the snapshot.
- Latency: a change sampled at IDLE edge N shows on d0..d3 at edge N+8. That is capture N, CONV N+1..N+6, COMMIT N+7, output register N+8.
- Output register, updated every cycle: d = committed BCD, then the blink mask, then the optional blank.
- Blink:
  - adj_en=0: counter held at 0, phase held at 0.
  - adj_en=1: counter counts 0..BLINK_DIV-1; the phase toggles on wrap.
  - While phase=1, the pair selected by adj_sel outputs BLANK_CODE.
  - Changing adj_sel does not reset the counter.
- Lap:
  - lap_pulse with lap_active=0 and adj_en=0 sets lap_active. Commits are then suppressed and the display stays frozen; conversion continues.
  - lap_pulse with lap_active=1 clears lap_active and sets reconvert. The fresh value appears within 16 cycles.
  - lap_pulse is ignored while adj_en=1.
  - adj_en=1 while lap_active=1 clears lap_active and sets reconvert.
- Simultaneous events:
  - lap release and an input change in the same cycle need a single conversion only.
  - RESET has priority over everything. Reset mid-conversion aborts the conversion and returns to IDLE.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: d3 outputs BLANK_CODE when the committed minutes-tens value is 0 and not dash. Blink and dash behaviour are unchanged.
- Undefined: d3 shows 0 normally.

Decomposition:
- Shared package/include disp_pkg holds:
  - FSM state encodings (IDLE/CONV/COMMIT);
  - default BLANK_CODE and DASH_CODE;
  - CONV_CYCLES=6 and BCD nibble width 4.
- Sub-module bin2bcd_seq: 6-bit sequential double-dabble with load/step inputs and an 8-bit BCD output. It is instantiated twice (minutes, seconds) and stepped by the disp_ctrl FSM.

Test Plan:
- Reset, then min=12, sec=34 -> busy high for 7 cycles; at edge N+8: d3..d0 = 1,2,3,4.
- sec=61 with min=5 -> d1=d0=DASH_CODE; d3,d2 = 0,5.
- lap_pulse, then sec steps 34->35->36 -> d unchanged and lap_active=1. Second lap_pulse -> d0=6 within 16 cycles, lap_active=0.
- BLINK_DIV=4, adj_en=1, adj_sel=1 -> d3,d2 alternate value/BLANK_CODE every 4 cycles; d1,d0 steady. adj_en=0 -> steady within 1 cycle.
- sec changes on every cycle during CONV -> final display equals the last value sampled in IDLE; no corrupted digits.
- RESET asserted at the 3rd CONV cycle -> next cycle: all outputs 0, busy 0. LEADING_ZERO_BLANK_EN build with min=5 -> d3=BLANK_CODE.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the stopwatch display controller.
// Holds the FSM encoding, default digit codes and BCD geometry.
package disp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_COMMIT
    } state_t;

    localparam int NIB_W = 4;
    localparam int CONV_CYCLES = 6;

    localparam logic [NIB_W-1:0] BLANK_CODE_DEF = 4'hF;
    localparam logic [NIB_W-1:0] DASH_CODE_DEF = 4'hA;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 6-bit double-dabble: load captures the binary value,
// each step does one add-3 pass and a left shift.
module bin2bcd_seq
    import disp_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic [5:0]           bin_i,
    output logic [2*NIB_W-1:0]   bcd_o
);

    localparam int SW = 2 * NIB_W + 6;

    logic [SW-1:0] sr_q;
    logic [SW-1:0] sr_d;
    logic [SW-1:0] adj;

    always_comb begin
        adj = sr_q;
        if (sr_q[9:6] >= 4'd5) begin
            adj[9:6] = sr_q[9:6] + 4'd3;
        end
        if (sr_q[13:10] >= 4'd5) begin
            adj[13:10] = sr_q[13:10] + 4'd3;
        end
        sr_d = sr_q;
        if (load_i) begin
            sr_d = {{(2*NIB_W){1'b0}}, bin_i};
        end else if (step_i) begin
            sr_d = {adj[SW-2:0], 1'b0};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign bcd_o = sr_q[SW-1:6];

endmodule

// File: rtl/disp_ctrl.sv
// Stopwatch display controller: BCD conversion, lap freeze, adjust blink.
// Optional LEADING_ZERO_BLANK_EN blanks a zero minutes-tens digit.
module disp_ctrl
    import disp_pkg::*;
#(
    parameter int         BLINK_DIV  = 25000000,
    parameter int         MAX_VAL    = 59,
    parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEF,
    parameter logic [3:0] DASH_CODE  = DASH_CODE_DEF
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [5:0] min_bin,
    input  logic [5:0] sec_bin,
    input  logic       adj_en,
    input  logic       adj_sel,
    input  logic       lap_pulse,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic       busy,
    output logic       lap_active
);

    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [6:0] MAX7 = 7'(MAX_VAL);
    localparam logic [2:0] CONV_LAST = 3'(CONV_CYCLES - 1);

    state_t state_q, state_d;
    logic [5:0] smin_q, smin_d;
    logic [5:0] ssec_q, ssec_d;
    logic [2:0] cnt_q, cnt_d;
    logic reconv_q, reconv_d;
    logic lap_q, lap_d;
    logic [3:0] c0_q, c1_q, c2_q, c3_q;
    logic [3:0] c0_d, c1_d, c2_d, c3_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic phase_q, phase_d;
    logic [3:0] d0_q, d1_q, d2_q, d3_q;
    logic [3:0] d0_d, d1_d, d2_d, d3_d;

    logic load;
    logic step;
    logic capture;
    logic lap_rel;
    logic min_dash;
    logic sec_dash;
    logic [7:0] bcd_min;
    logic [7:0] bcd_sec;

    bin2bcd_seq u_min (
        .CLK    (CLK),
        .RESET  (RESET),
        .load_i (load),
        .step_i (step),
        .bin_i  (min_bin),
        .bcd_o  (bcd_min)
    );

    bin2bcd_seq u_sec (
        .CLK    (CLK),
        .RESET  (RESET),
        .load_i (load),
        .step_i (step),
        .bin_i  (sec_bin),
        .bcd_o  (bcd_sec)
    );

    assign capture = (state_q == S_IDLE) &&
                     (({min_bin, sec_bin} != {smin_q, ssec_q}) || reconv_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        smin_d  = smin_q;
        ssec_d  = ssec_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (capture) begin
                    load    = 1'b1;
                    smin_d  = min_bin;
                    ssec_d  = sec_bin;
                    cnt_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                step  = 1'b1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == CONV_LAST) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // A release in the same cycle as a capture needs no second pass.
    always_comb begin
        lap_rel  = lap_q && (adj_en || lap_pulse);
        lap_d    = lap_q;
        reconv_d = reconv_q;
        if (lap_rel) begin
            lap_d    = 1'b0;
            reconv_d = 1'b1;
        end else if (lap_pulse && !adj_en) begin
            lap_d = 1'b1;
        end
        if (capture) begin
            reconv_d = 1'b0;
        end
    end

    always_comb begin
        min_dash = {1'b0, smin_q} > MAX7;
        sec_dash = {1'b0, ssec_q} > MAX7;
        c0_d = c0_q;
        c1_d = c1_q;
        c2_d = c2_q;
        c3_d = c3_q;
        if (state_q == S_COMMIT && !lap_q) begin
            c3_d = min_dash ? DASH_CODE : bcd_min[7:4];
            c2_d = min_dash ? DASH_CODE : bcd_min[3:0];
            c1_d = sec_dash ? DASH_CODE : bcd_sec[7:4];
            c0_d = sec_dash ? DASH_CODE : bcd_sec[3:0];
        end
    end

    always_comb begin
        bcnt_d  = '0;
        phase_d = 1'b0;
        if (adj_en) begin
            phase_d = phase_q;
            if (bcnt_q == BLINK_LAST) begin
                phase_d = !phase_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end
    end

    // Gating on adj_en lets the display go steady on the very next edge.
    always_comb begin
        d0_d = c0_q;
        d1_d = c1_q;
        d2_d = c2_q;
        d3_d = c3_q;
        if (adj_en && phase_q) begin
            if (adj_sel) begin
                d3_d = BLANK_CODE;
                d2_d = BLANK_CODE;
            end else begin
                d1_d = BLANK_CODE;
                d0_d = BLANK_CODE;
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        if (c3_q == 4'd0 && c3_q != DASH_CODE) begin
            d3_d = BLANK_CODE;
        end
`else
        d3_d = d3_d;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            smin_q   <= '0;
            ssec_q   <= '0;
            reconv_q <= 1'b0;
            lap_q    <= 1'b0;
            c0_q     <= '0;
            c1_q     <= '0;
            c2_q     <= '0;
            c3_q     <= '0;
            bcnt_q   <= '0;
            phase_q  <= 1'b0;
            d0_q     <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            d3_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            smin_q   <= smin_d;
            ssec_q   <= ssec_d;
            reconv_q <= reconv_d;
            lap_q    <= lap_d;
            c0_q     <= c0_d;
            c1_q     <= c1_d;
            c2_q     <= c2_d;
            c3_q     <= c3_d;
            bcnt_q   <= bcnt_d;
            phase_q  <= phase_d;
            d0_q     <= d0_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            d3_q     <= d3_d;
        end
    end

    assign d0 = d0_q;
    assign d1 = d1_q;
    assign d2 = d2_q;
    assign d3 = d3_q;
    assign busy = (state_q != S_IDLE);
    assign lap_active = lap_q;

endmodule

// File: tb/tb_disp_ctrl.sv
// Self-checking bench for disp_ctrl: directed steps plus random traffic
// against a digit-level reference model (tens = v/10, ones = v%10).
module tb_disp_ctrl;

    localparam int BD = 4;

    logic CLK = 1'b0;
    logic RESET;
    logic [5:0] min_bin;
    logic [5:0] sec_bin;
    logic adj_en;
    logic adj_sel;
    logic lap_pulse;
    logic [3:0] d0, d1, d2, d3;
    logic busy;
    logic lap_active;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    disp_ctrl #(.BLINK_DIV(BD)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .min_bin    (min_bin),
        .sec_bin    (sec_bin),
        .adj_en     (adj_en),
        .adj_sel    (adj_sel),
        .lap_pulse  (lap_pulse),
        .d0         (d0),
        .d1         (d1),
        .d2         (d2),
        .d3         (d3),
        .busy       (busy),
        .lap_active (lap_active)
    );

    // Reference model: a conversion is a 7-cycle busy window whose
    // result is the decimal split of the captured snapshot.
    int m_smin, m_ssec, m_timer, m_bcnt;
    bit m_reconv, m_lap, m_phase;
    logic [3:0] m_c [4];
    logic [3:0] m_d [4];

    function automatic logic [7:0] pair(int v);
        logic [3:0] t, o;
        if (v > 59) return 8'hAA;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_smin = 0; m_ssec = 0; m_timer = 0; m_bcnt = 0;
        m_reconv = 0; m_lap = 0; m_phase = 0;
        for (int i = 0; i < 4; i++) begin
            m_c[i] = 4'd0;
            m_d[i] = 4'd0;
        end
    endtask

    task automatic tick();
        bit cap, rel;
        logic [7:0] p;
        if (RESET) begin
            model_reset();
        end else begin
            for (int i = 0; i < 4; i++) m_d[i] = m_c[i];
            if (adj_en && m_phase) begin
                if (adj_sel) begin
                    m_d[3] = 4'hF; m_d[2] = 4'hF;
                end else begin
                    m_d[1] = 4'hF; m_d[0] = 4'hF;
                end
            end
`ifdef LEADING_ZERO_BLANK_EN
            if (m_c[3] == 4'd0) m_d[3] = 4'hF;
`endif
            if (m_timer == 1 && !m_lap) begin
                p = pair(m_smin); m_c[3] = p[7:4]; m_c[2] = p[3:0];
                p = pair(m_ssec); m_c[1] = p[7:4]; m_c[0] = p[3:0];
            end
            cap = (m_timer == 0) &&
                  (int'(min_bin) != m_smin || int'(sec_bin) != m_ssec || m_reconv);
            rel = m_lap && (adj_en || lap_pulse);
            if (m_timer > 0) m_timer--;
            else if (cap) begin
                m_timer = 7;
                m_smin = int'(min_bin);
                m_ssec = int'(sec_bin);
            end
            if (rel) begin
                m_lap = 0; m_reconv = 1;
            end else if (lap_pulse && !adj_en) begin
                m_lap = 1;
            end
            if (cap) m_reconv = 0;
            if (!adj_en) begin
                m_bcnt = 0; m_phase = 0;
            end else if (m_bcnt == BD - 1) begin
                m_bcnt = 0; m_phase = !m_phase;
            end else begin
                m_bcnt++;
            end
        end
        @(posedge CLK);
        #1;
        chk("d0", d0, m_d[0]);
        chk("d1", d1, m_d[1]);
        chk("d2", d2, m_d[2]);
        chk("d3", d3, m_d[3]);
        chk("busy", busy, m_timer != 0);
        chk("lap_active", lap_active, m_lap);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [3:0] d3_min5;
    int nbusy;

    initial begin
`ifdef LEADING_ZERO_BLANK_EN
        d3_min5 = 4'hF;
`else
        d3_min5 = 4'h0;
`endif
        model_reset();
        RESET = 1; min_bin = 0; sec_bin = 0;
        adj_en = 0; adj_sel = 0; lap_pulse = 0;
        #1;
        ticks(2);
        chk("rst_d0", d0, 4'd0);
        chk("rst_d3", d3, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_lap", lap_active, 1'b0);

        RESET = 0;
        min_bin = 6'd12; sec_bin = 6'd34;
        nbusy = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy) nbusy++;
        end
        chk("busy_len", nbusy, 7);
        chk("lat_d0_not_yet", d0, 4'd0);
        tick();
        chk("n8_d3", d3, 4'd1);
        chk("n8_d2", d2, 4'd2);
        chk("n8_d1", d1, 4'd3);
        chk("n8_d0", d0, 4'd4);

        min_bin = 6'd5; sec_bin = 6'd61;
        ticks(10);
        chk("dash_d1", d1, 4'hA);
        chk("dash_d0", d0, 4'hA);
        chk("dash_d2", d2, 4'd5);
        chk("dash_d3", d3, d3_min5);

        min_bin = 6'd12; sec_bin = 6'd34;
        ticks(10);
        lap_pulse = 1; tick(); lap_pulse = 0;
        sec_bin = 6'd35; ticks(10);
        sec_bin = 6'd36; ticks(10);
        chk("lap_frozen_d0", d0, 4'd4);
        chk("lap_on", lap_active, 1'b1);
        lap_pulse = 1; tick(); lap_pulse = 0;
        ticks(15);
        chk("lap_rel_d0", d0, 4'd6);
        chk("lap_off", lap_active, 1'b0);

        adj_en = 1; adj_sel = 1;
        ticks(20);
        adj_en = 0;
        tick();
        chk("blink_off_d3", d3, 4'd1);
        chk("blink_off_d2", d2, 4'd2);

        for (int i = 0; i < 9; i++) begin
            sec_bin = 6'($urandom_range(0, 63));
            tick();
        end
        ticks(12);

        min_bin = 6'd33;
        ticks(3);
        RESET = 1;
        tick();
        chk("mid_rst_d0", d0, 4'd0);
        chk("mid_rst_d2", d2, 4'd0);
        chk("mid_rst_busy", busy, 1'b0);
        RESET = 0;
        ticks(10);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) min_bin = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) sec_bin = 6'($urandom_range(0, 63));
            lap_pulse = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 39) == 0) adj_en = !adj_en;
            if ($urandom_range(0, 9) == 0) adj_sel = !adj_sel;
            RESET = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
